// File: rtl/serial_comp_ctrl_if.sv
// Host and comparator-slice signal bundle for serial_comp_ctrl.
// The slave modport is the controller; the master side issues requests and hosts the 2-bit slice.
interface serial_comp_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       slice_a;
  logic [1:0]       slice_b;
  logic             slice_eq_in;
  logic             slice_gt_in;
  logic             slice_eq_out;
  logic             slice_gt_out;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;
  logic             err;

  modport slave (
    input  start, a, b, slice_eq_out, slice_gt_out,
    output slice_a, slice_b, slice_eq_in, slice_gt_in,
    output busy, done, eq, gt, lt, err
  );

  modport master (
    output start, a, b, slice_eq_out, slice_gt_out,
    input  slice_a, slice_b, slice_eq_in, slice_gt_in,
    input  busy, done, eq, gt, lt, err
  );
endinterface

// File: rtl/serial_comp_ctrl.sv
// Serial unsigned magnitude comparator controller: walks operand bit pairs MSB-first
// through an external 2-bit cascade slice, exiting early on the first unequal pair.
module serial_comp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_comp_ctrl_if.slave   bus
);

  localparam int                PAIRS   = WIDTH / 2;
  localparam int                IDX_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(PAIRS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
    logic err;
  } flags_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  flags_t           flags_q, flags_d;

  logic [1:0]       slice_a;
  logic [1:0]       slice_b;
  logic             slice_eq_in;
  logic             slice_gt_in;
  logic [IDX_W:0]   pair_lsb;

  assign pair_lsb = {idx_q, 1'b0};

  // NOTE: the operand registers are reset too: they are small flops, not a memory,
  // and clearing them keeps the slice inputs and any debug view deterministic.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      flags_q <= flags_d;
    end
  end

  // NOTE: every signal written here is given a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    flags_d     = flags_q;
    slice_a     = 2'b00;
    slice_b     = 2'b00;
    slice_eq_in = 1'b0;
    slice_gt_in = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = IDX_TOP;
          flags_d = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Each pair is compared in isolation: the cascade is seeded as "equal so far".
        slice_a     = a_q[pair_lsb +: 2];
        slice_b     = b_q[pair_lsb +: 2];
        slice_eq_in = 1'b1;
        slice_gt_in = 1'b0;

        if (bus.slice_eq_out && bus.slice_gt_out) begin
          flags_d     = '0;
          flags_d.err = 1'b1;
          state_d     = DONE;
        end else if (!bus.slice_eq_out) begin
          flags_d     = '0;
          flags_d.gt  = bus.slice_gt_out;
          flags_d.lt  = !bus.slice_gt_out;
          state_d     = DONE;
        end else if (idx_q == '0) begin
          flags_d     = '0;
          flags_d.eq  = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d       = idx_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.slice_a     = slice_a;
  assign bus.slice_b     = slice_b;
  assign bus.slice_eq_in = slice_eq_in;
  assign bus.slice_gt_in = slice_gt_in;
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.eq          = flags_q.eq;
  assign bus.gt          = flags_q.gt;
  assign bus.lt          = flags_q.lt;
  assign bus.err         = flags_q.err;

  // A result is always exactly one of eq/gt/lt/err, and busy never overlaps done.
  a_one_hot_at_done : assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == DONE) |-> $onehot({flags_q.eq, flags_q.gt, flags_q.lt, flags_q.err})
  );

  a_busy_done_excl : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(bus.busy && bus.done)
  );

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Bench for serial_comp_ctrl: directed operand pairs with a behavioural 2-bit slice;
// a scoreboard queue holds expected flags/latency, popped by a monitor on each done.
module tb_serial_comp_ctrl;

  localparam int WIDTH = 8;

  localparam logic [3:0] F_EQ  = 4'b1000;
  localparam logic [3:0] F_GT  = 4'b0100;
  localparam logic [3:0] F_LT  = 4'b0010;
  localparam logic [3:0] F_ERR = 4'b0001;

  typedef struct {
    logic [3:0] flags;
    int         k;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fault = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  serial_comp_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_comp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Behavioural slice, with a fault mode that asserts both results.
  assign bus.slice_eq_out = fault | (bus.slice_eq_in & (bus.slice_a == bus.slice_b));
  assign bus.slice_gt_out = fault | bus.slice_gt_in | (bus.slice_eq_in & (bus.slice_a > bus.slice_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      check("busy_done_excl", bus.busy, 1'b0);
      check("done_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result_flags", {bus.eq, bus.gt, bus.lt, bus.err}, e.flags);
        check("latency", cyc - e.acc + 1, e.k + 1);
      end
    end
  end

  // Issue one comparison. With hold_start, start stays high and a/b are scrambled
  // during RUN; start drops only on the done cycle.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [3:0] flags, input int k, input bit hold_start);
    int  busy_cnt;
    bit  seen;
    busy_cnt = 0;
    seen     = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    exp_q.push_back('{flags: flags, k: k, acc: cyc + 1});
    @(negedge clk);
    check("slice_a_msb", bus.slice_a, ta[7:6]);
    check("slice_b_msb", bus.slice_b, tb_v[7:6]);
    check("slice_cascade_in", {bus.slice_eq_in, bus.slice_gt_in}, 2'b10);
    if (!hold_start) bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (hold_start) begin
        bus.a = ~bus.a;
        bus.b = bus.b + 8'h35;
      end
      @(negedge clk);
    end
    check("done_seen", seen, 1'b1);
    check("busy_cycles", busy_cnt, k);
    if (hold_start) begin
      bus.start = 1'b0;
      repeat (2) begin
        @(negedge clk);
        check("no_rerun_busy", bus.busy, 1'b0);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state
    #2;
    check("rst_busy_done", {bus.busy, bus.done}, 2'b00);
    check("rst_flags", {bus.eq, bus.gt, bus.lt, bus.err}, 4'b0000);
    check("rst_slice", {bus.slice_a, bus.slice_b, bus.slice_eq_in, bus.slice_gt_in}, 6'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Equal operands: all four pairs examined
    run_op(8'hA5, 8'hA5, F_EQ, 4, 1'b0);
    // Early exit on the MSB pair
    run_op(8'h80, 8'h7F, F_GT, 1, 1'b0);
    // Difference only in the LSB pair, then flags hold while idle
    run_op(8'h12, 8'h13, F_LT, 4, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("hold_flags", {bus.eq, bus.gt, bus.lt, bus.err}, F_LT);
      check("idle_busy", bus.busy, 1'b0);
      check("idle_slice", {bus.slice_a, bus.slice_b, bus.slice_eq_in}, 5'b0);
    end
    // Exit on the third pair, and a less-than on the MSB pair
    run_op(8'h4E, 8'h4A, F_GT, 3, 1'b0);
    run_op(8'h00, 8'h40, F_LT, 1, 1'b0);

    // start held through RUN with operands changing underneath
    run_op(8'h5A, 8'h5B, F_LT, 4, 1'b1);

    // Faulty slice reports both equal and greater
    fault = 1'b1;
    run_op(8'h33, 8'h11, F_ERR, 1, 1'b0);
    fault = 1'b0;

    // Reset in the second RUN cycle aborts with no done
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h13;
    exp_q.push_back('{flags: F_LT, k: 4, acc: cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy_done", {bus.busy, bus.done}, 2'b00);
    check("abort_flags", {bus.eq, bus.gt, bus.lt, bus.err}, 4'b0000);
    check("abort_slice", {bus.slice_a, bus.slice_b, bus.slice_eq_in}, 5'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("abort_no_done", bus.done, 1'b0);
    rst_n = 1'b1;
    run_op(8'hFF, 8'hFF, F_EQ, 4, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_comp_ctrl.md
SERIAL_COMP_CTRL -- requirements
Module: serial_comp_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be even and >= 2.
REQ-002 Port: clk  input  1  rising-edge clock; the block's only clock.
REQ-003 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port: start  input  1  request a comparison; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A (unsigned); captured on start accept.
REQ-006 Port: b  input  WIDTH  operand B (unsigned); captured on start accept.
REQ-007 Port: slice_a  output  2  bit pair of A presented to the external 2-bit comparator slice.
REQ-008 Port: slice_b  output  2  bit pair of B presented to the slice.
REQ-009 Port: slice_eq_in  output  1  cascade "equal so far" into slice (EQ1).
REQ-010 Port: slice_gt_in  output  1  cascade "greater so far" into slice (GT1).
REQ-011 Port: slice_eq_out  input  1  slice result EQ0, combinational from slice inputs.
REQ-012 Port: slice_gt_out  input  1  slice result GT0, combinational from slice inputs.
REQ-013 Port: busy  output  1  high while in RUN.
REQ-014 Port: done  output  1  one-cycle pulse when result becomes valid.
REQ-015 Port: eq / gt / lt  output  1 each  result flags; held from done until next start accept.
REQ-016 Port: err  output  1  slice returned EQ0=1 and GT0=1; held like result flags.

Function
REQ-017 FSM SHALL have states IDLE, RUN, DONE; one state per clock.
REQ-018 IDLE: start=1 -> latch a, b; pair index idx=WIDTH/2-1; clear eq/gt/lt/err; next RUN.
REQ-019 IDLE: start=0 -> stay; result flags hold.
REQ-020 RUN: slice_a=A[2*idx+1:2*idx], slice_b=B[2*idx+1:2*idx], slice_eq_in=1, slice_gt_in=0 (MSB pair first).
REQ-021 Outside RUN, slice_a, slice_b, slice_eq_in and slice_gt_in SHALL be 0.
REQ-022 RUN, slice_eq_out=1 and slice_gt_out=1 -> err=1, eq=gt=lt=0, next DONE.
REQ-023 RUN, slice_eq_out=0 -> early exit: gt=slice_gt_out, lt=~slice_gt_out, eq=0, next DONE.
REQ-024 RUN, slice_eq_out=1, slice_gt_out=0, idx=0 -> eq=1, gt=lt=0, next DONE.
REQ-025 RUN, slice_eq_out=1, slice_gt_out=0, idx>0 -> idx decrements by 1, stay RUN.
REQ-026 Latency: start accept to done is k+1 cycles, where k is the number of pairs examined; worst case WIDTH/2+1 cycles.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-028 start SHALL be ignored in RUN and DONE; no queuing. Changes on a/b after accept SHALL NOT affect the result.
REQ-029 Exactly one of eq, gt, lt, err SHALL be 1 whenever done=1.
REQ-030 busy SHALL be 1 in RUN only; busy and done SHALL never both be 1.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, idx=0, latched operands=0, and busy=done=eq=gt=lt=err=0, regardless of clk.
REQ-032 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-033 The first start accept SHALL occur on the first rising clk edge with rst_n=1 and start=1.

Verification (WIDTH=8, behavioural 2-bit slice model attached)
REQ-034 a=0xA5, b=0xA5, start for 1 cycle -> busy for 4 cycles; done on cycle 5 with eq=1, gt=lt=err=0.
REQ-035 a=0x80, b=0x7F -> early exit on first pair; done 2 cycles after accept with gt=1.
REQ-036 a=0x12, b=0x13 -> 4 pairs examined; lt=1 at done; flags hold 0/0/1 through 3 idle cycles.
REQ-037 start held high through RUN with a/b changed mid-run -> single done, original result, no second run until IDLE.
REQ-038 Faulty slice forcing EQ0=GT0=1 -> err=1 at done, eq=gt=lt=0.
REQ-039 rst_n low during second RUN cycle -> all outputs 0 asynchronously, no done; a new start after release completes normally.
